// File: rtl/i2c_wb_arbiter.sv
// Two-requester Wishbone arbiter in front of a shared I2C master slave port.
// Define I2C_ARB_TIMEOUT_EN to enable the stall watchdog that aborts a hung transfer.
module i2c_wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t r_state;
    state_t w_next;
    logic   r_last;     // 1: m1 owned last, so m0 wins the next tie
    logic   w_own0;
    logic   w_own1;
    logic   w_req0;
    logic   w_req1;
    logic   w_abort;

    // Ownership is masked by reset so nothing leaks out while reset is held.
    assign w_own0 = (r_state == OWN0) && !wb_rst_i;
    assign w_own1 = (r_state == OWN1) && !wb_rst_i;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_tcnt;
    logic [1:0]  r_err;
    logic [1:0]  r_blk;
    logic        w_stall;

    assign w_stall = (w_own0 || w_own1) && s_stb_o && !s_ack_i;
    assign w_abort = w_stall && (r_tcnt == LP_TMO_LAST);
    assign w_req0  = m0_cyc_i && !r_blk[0];
    assign w_req1  = m1_cyc_i && !r_blk[1];

    // An aborted requester stays blocked until it has released cyc once.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_tcnt <= '0;
            r_err  <= '0;
            r_blk  <= '0;
        end else begin
            r_err <= w_abort ? {w_own1, w_own0} : 2'b00;
            r_blk <= (r_blk & {m1_cyc_i, m0_cyc_i}) | (w_abort ? {w_own1, w_own0} : 2'b00);
            if ((w_next != r_state) || s_ack_i)
                r_tcnt <= '0;
            else if (w_stall)
                r_tcnt <= r_tcnt + 16'd1;
        end
    end

    assign m0_err_o  = r_err[0] && !wb_rst_i;
    assign m1_err_o  = r_err[1] && !wb_rst_i;
    assign timeout_o = (|r_err) && !wb_rst_i;
`else
    assign w_abort   = 1'b0;
    assign w_req0    = m0_cyc_i;
    assign w_req1    = m1_cyc_i;
    assign m0_err_o  = 1'b0;
    assign m1_err_o  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == OWN0 && w_next == IDLE)
                r_last <= 1'b0;
            else if (r_state == OWN1 && w_next == IDLE)
                r_last <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req0 && w_req1)
                    w_next = r_last ? OWN0 : OWN1;
                else if (w_req0)
                    w_next = OWN0;
                else if (w_req1)
                    w_next = OWN1;
            end
            OWN0:    if (!m0_cyc_i || w_abort) w_next = IDLE;
            OWN1:    if (!m1_cyc_i || w_abort) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (w_own0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_cyc_i && m0_stb_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (w_own1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_cyc_i && m1_stb_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    assign m0_ack_o = w_own0 && s_ack_i && m0_cyc_i;
    assign m1_ack_o = w_own1 && s_ack_i && m1_cyc_i;
    assign m0_dat_o = w_own0 ? s_dat_i : '0;
    assign m1_dat_o = w_own1 ? s_dat_i : '0;
    assign grant_o  = {w_own1, w_own0};

endmodule

// File: tb/tb_i2c_wb_arbiter.sv
// Self-checking bench for i2c_wb_arbiter: directed scenarios plus randomized traffic
// checked every cycle against an ownership-level reference model.
module tb_i2c_wb_arbiter;

    localparam int unsigned TB_TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mcyc, mstb, mwe;
    logic [3:0]  msel [2];
    logic [31:0] madr [2];
    logic [31:0] mdat [2];
    logic [31:0] s_dat;
    logic        s_ack;

    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [1:0]  grant_o;
    logic        timeout_o;

    always #5 clk = ~clk;

    i2c_wb_arbiter #(.TIMEOUT_CYCLES(TB_TMO)) dut (
        .wb_clk_i (clk),       .wb_rst_i (rst),
        .m0_cyc_i (mcyc[0]),   .m0_stb_i (mstb[0]),   .m0_we_i (mwe[0]),
        .m0_sel_i (msel[0]),   .m0_adr_i (madr[0]),   .m0_dat_i (mdat[0]),
        .m0_dat_o (m0_dat_o),  .m0_ack_o (m0_ack_o),  .m0_err_o (m0_err_o),
        .m1_cyc_i (mcyc[1]),   .m1_stb_i (mstb[1]),   .m1_we_i (mwe[1]),
        .m1_sel_i (msel[1]),   .m1_adr_i (madr[1]),   .m1_dat_i (mdat[1]),
        .m1_dat_o (m1_dat_o),  .m1_ack_o (m1_ack_o),  .m1_err_o (m1_err_o),
        .s_cyc_o  (s_cyc_o),   .s_stb_o  (s_stb_o),   .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),   .s_adr_o  (s_adr_o),   .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat),     .s_ack_i  (s_ack),
        .grant_o  (grant_o),   .timeout_o(timeout_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the port (0 none, 1 m0, 2 m1) and who owned it last.
    int       m_own  = 0;
    int       m_last = 1;
    bit [1:0] m_err  = 2'b00;
    bit [1:0] m_blk  = 2'b00;
`ifdef I2C_ARB_TIMEOUT_EN
    int       m_cnt  = 0;
`endif

    task automatic model_update();
        bit [1:0] want;
        int       k;
        if (rst) begin
            m_own = 0; m_last = 1; m_err = 2'b00; m_blk = 2'b00;
`ifdef I2C_ARB_TIMEOUT_EN
            m_cnt = 0;
`endif
            return;
        end
        m_err = 2'b00;
        m_blk = m_blk & mcyc;
        if (m_own == 0) begin
            want = mcyc & ~m_blk;
            if (want == 2'b11)      m_own = (m_last == 0) ? 2 : 1;
            else if (want[0])       m_own = 1;
            else if (want[1])       m_own = 2;
        end else begin
            k = m_own - 1;
            if (!mcyc[k]) begin
                m_last = k; m_own = 0;
`ifdef I2C_ARB_TIMEOUT_EN
                m_cnt = 0;
`endif
            end
`ifdef I2C_ARB_TIMEOUT_EN
            else if (s_ack) m_cnt = 0;
            else if (mstb[k]) begin
                m_cnt++;
                if (m_cnt == TB_TMO) begin
                    m_err[k] = 1'b1; m_blk[k] = 1'b1;
                    m_last = k; m_own = 0; m_cnt = 0;
                end
            end
`endif
        end
    endtask

    task automatic check_outputs();
        int          o, k;
        logic [1:0]  eg;
        logic        ecyc, estb, ewe;
        logic [3:0]  esel;
        logic [31:0] eadr, edat, ed0, ed1;
        logic        ea0, ea1;
        logic [1:0]  ee;
        o = rst ? 0 : m_own;
        eg = (o == 1) ? 2'b01 : (o == 2) ? 2'b10 : 2'b00;
        ecyc = 1'b0; estb = 1'b0; ewe = 1'b0; esel = '0; eadr = '0; edat = '0;
        ed0 = '0; ed1 = '0; ea0 = 1'b0; ea1 = 1'b0;
        if (o != 0) begin
            k = o - 1;
            ecyc = mcyc[k]; estb = mcyc[k] & mstb[k]; ewe = mwe[k];
            esel = msel[k]; eadr = madr[k]; edat = mdat[k];
            if (k == 0) begin ea0 = s_ack & mcyc[0]; ed0 = s_dat; end
            else        begin ea1 = s_ack & mcyc[1]; ed1 = s_dat; end
        end
        ee = rst ? 2'b00 : m_err;
        check("grant",   32'(grant_o), 32'(eg));
        check("s_cyc",   32'(s_cyc_o), 32'(ecyc));
        check("s_stb",   32'(s_stb_o), 32'(estb));
        check("s_we",    32'(s_we_o),  32'(ewe));
        check("s_sel",   32'(s_sel_o), 32'(esel));
        check("s_adr",   s_adr_o, eadr);
        check("s_dat",   s_dat_o, edat);
        check("m0_ack",  32'(m0_ack_o), 32'(ea0));
        check("m1_ack",  32'(m1_ack_o), 32'(ea1));
        check("m0_dat",  m0_dat_o, ed0);
        check("m1_dat",  m1_dat_o, ed1);
        check("err",     32'({m1_err_o, m0_err_o}), 32'(ee));
        check("timeout", 32'(timeout_o), 32'(|ee));
    endtask

    logic [1:0] seen_grant, seen_ack, seen_err;
    logic       seen_tmo, seen_scyc;
    logic [1:0] glog [$];

    // One clock: inputs were set just after the previous edge.
    task automatic step();
        @(negedge clk);
        check_outputs();
        seen_grant = grant_o;
        seen_ack   = {m1_ack_o, m0_ack_o};
        seen_err   = {m1_err_o, m0_err_o};
        seen_tmo   = timeout_o;
        seen_scyc  = s_cyc_o;
        glog.push_back(grant_o);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        mcyc = '0; mstb = '0; mwe = '0; s_ack = 1'b0; s_dat = '0;
        for (int n = 0; n < 2; n++) begin
            msel[n] = '0; madr[n] = '0; mdat[n] = '0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int       acks, idx;
        int       reads [2];
        logic [1:0] prev;
        logic [1:0] seq [$];

        idle_inputs();
        rst = 1'b1;
        do_reset();
        step();
        check("rst_grant",   32'(seen_grant), 32'd0);
        check("rst_timeout", 32'(seen_tmo),   32'd0);
        check("rst_err",     32'(seen_err),   32'd0);
        check("rst_scyc",    32'(seen_scyc),  32'd0);

        // Single write from m0, slave acks on the third owned cycle.
        do_reset();
        mcyc[0] = 1; mstb[0] = 1; mwe[0] = 1; msel[0] = 4'hF;
        madr[0] = 32'h0000_0004; mdat[0] = 32'h55;
        acks = 0;
        step();  check("s1_pre_grant", 32'(seen_grant), 32'd0);
        step();  check("s1_grant",     32'(seen_grant), 32'd1);  acks += int'(seen_ack[0]);
        step();  acks += int'(seen_ack[0]);
        s_ack = 1;
        step();  acks += int'(seen_ack[0]);
        mcyc[0] = 0; mstb[0] = 0; s_ack = 0;
        step();  acks += int'(seen_ack[0]);
        step();  check("s1_release",   32'(seen_grant), 32'd0);
        check("s1_ack_pulses", 32'(acks), 32'd1);

        // Both request together, four single-beat reads each: strict alternation.
        do_reset();
        glog.delete();
        reads[0] = 4; reads[1] = 4; mcyc = 2'b11; mstb = 2'b11; s_ack = 1;
        for (int i = 0; i < 80 && (reads[0] + reads[1] != 0 || mcyc != 2'b00); i++) begin
            s_dat = $urandom;
            step();
            for (int n = 0; n < 2; n++) begin
                if (mcyc[n] && seen_ack[n]) begin
                    mcyc[n] = 0; reads[n]--;
                end else if (!mcyc[n] && reads[n] > 0) begin
                    mcyc[n] = 1;
                end
            end
            mstb = mcyc;
        end
        s_ack = 0;
        prev = 2'b00;
        seq.delete();
        foreach (glog[i]) begin
            if (glog[i] != 2'b00 && glog[i] != prev) begin
                check("s2_idle_gap", 32'(prev), 32'd0);
                seq.push_back(glog[i]);
            end
            prev = glog[i];
        end
        check("s2_grants", 32'(seq.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            idx = (i % 2 == 0) ? 1 : 2;
            check("s2_order", (i < seq.size()) ? 32'(seq[i]) : 32'hFFFF_FFFF, 32'(idx));
        end

        // m1 holds a 3-beat locked cycle; m0 asks during beat 1.
        do_reset();
        mcyc[1] = 1; mstb[1] = 1;
        step();
        mcyc[0] = 1; mstb[0] = 1; s_ack = 1;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("s3_locked", 32'(seen_grant), 32'd2);
            acks += int'(seen_ack[1]);
        end
        check("s3_m1_beats", 32'(acks), 32'd3);
        mcyc[1] = 0; mstb[1] = 0; s_ack = 0;
        step();  check("s3_drop",  32'(seen_grant), 32'd2);
        step();  check("s3_idle",  32'(seen_grant), 32'd0);
        step();  check("s3_m0",    32'(seen_grant), 32'd1);
        mcyc = '0; mstb = '0;
        step();

        // Slave never acks.
        do_reset();
        mcyc[0] = 1; mstb[0] = 1; madr[0] = 32'h10;
        step();
`ifdef I2C_ARB_TIMEOUT_EN
        for (int i = 0; i < int'(TB_TMO); i++) begin
            step();
            check("s4_stall_grant", 32'(seen_grant), 32'd1);
            check("s4_stall_err",   32'(seen_err),   32'd0);
        end
        step();
        check("s4_abort_grant", 32'(seen_grant), 32'd0);
        check("s4_abort_err",   32'(seen_err),   32'd1);
        check("s4_abort_tmo",   32'(seen_tmo),   32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("s4_blocked", 32'(seen_grant), 32'd0);
            check("s4_err_once", 32'(seen_err), 32'd0);
        end
        mcyc[0] = 0; mstb[0] = 0;
        step();
        mcyc[0] = 1; mstb[0] = 1;
        step();  check("s4_regrant_wait", 32'(seen_grant), 32'd0);
        step();  check("s4_regrant",      32'(seen_grant), 32'd1);
`else
        for (int i = 0; i < 100; i++) begin
            step();
            check("s4_hold_grant", 32'(seen_grant), 32'd1);
            check("s4_hold_err",   32'(seen_err),   32'd0);
            check("s4_hold_tmo",   32'(seen_tmo),   32'd0);
        end
`endif
        mcyc = '0; mstb = '0;
        step();

        // Reset lands while m1 waits for read data.
        do_reset();
        mcyc[1] = 1; mstb[1] = 1; madr[1] = 32'h20;
        step();
        step();  check("s5_owned", 32'(seen_grant), 32'd2);
        rst = 1;
        step();
        rst = 0; s_ack = 1; s_dat = 32'hDEAD_BEEF;
        step();
        check("s5_scyc",  32'(seen_scyc),   32'd0);
        check("s5_grant", 32'(seen_grant),  32'd0);
        check("s5_ack",   32'(seen_ack[1]), 32'd0);
        mcyc = '0; mstb = '0; s_ack = 0;
        step();

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(0, 4) == 0) mcyc[n] = ~mcyc[n];
                mstb[n] = mcyc[n] ? ($urandom_range(0, 3) != 0) : 1'($urandom);
                mwe[n]  = 1'($urandom);
                msel[n] = 4'($urandom);
                madr[n] = $urandom;
                mdat[n] = $urandom;
            end
            s_ack = ($urandom_range(0, 2) == 0);
            s_dat = $urandom;
            step();
        end

        rst = 0;
        idle_inputs();
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_wb_arbiter.md
I2C_WB_ARBITER -- requirements
Module: i2c_wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: stall-cycle limit before a granted transfer is aborted (range 2..65535).
REQ-002 SHALL have port wb_clk_i, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port wb_rst_i, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have ports mN_cyc_i (N=0,1), input, 1 each: requester N bus cycle; also serves as its request.
REQ-005 SHALL have ports mN_stb_i, input, 1 each: requester N strobe.
REQ-006 SHALL have ports mN_we_i, input, 1 each: requester N write enable.
REQ-007 SHALL have ports mN_sel_i, input, 4 each: requester N byte selects.
REQ-008 SHALL have ports mN_adr_i, input, 32 each: requester N address.
REQ-009 SHALL have ports mN_dat_i, input, 32 each: requester N write data.
REQ-010 SHALL have ports mN_dat_o, output, 32 each: read data; 0 when N not granted.
REQ-011 SHALL have ports mN_ack_o, output, 1 each: acknowledge; 0 when N not granted.
REQ-012 SHALL have ports mN_err_o, output, 1 each: one-cycle timeout abort indication.
REQ-013 SHALL have ports s_cyc_o, s_stb_o, s_we_o (1 each), s_sel_o (4), s_adr_o (32), s_dat_o (32), outputs: shared I2C master slave-port drive.
REQ-014 SHALL have port s_dat_i, input, 32: I2C master read data.
REQ-015 SHALL have port s_ack_i, input, 1: I2C master acknowledge.
REQ-016 SHALL have port grant_o, output, 2: one-hot current owner; 2'b00 when idle.
REQ-017 SHALL have port timeout_o, output, 1: one-cycle pulse when any abort occurs.

Function
REQ-018 SHALL implement FSM states IDLE, OWN0, OWN1.
REQ-019 IDLE: only m0_cyc_i high -> OWN0; only m1_cyc_i high -> OWN1; both high -> state for requester not equal to last_owner; neither -> stay IDLE.
REQ-020 Grant latency SHALL be exactly one cycle: request sampled in cycle N, grant_o and slave drive valid in cycle N+1.
REQ-021 OWNn SHALL persist while mn_cyc_i high (multi-beat cycles locked); mn_cyc_i low -> IDLE next cycle, last_owner <= n.
REQ-022 Two back-to-back owners SHALL be separated by at least one IDLE cycle; slave signals all 0 in IDLE.
REQ-023 While OWNn: s_cyc_o = mn_cyc_i, s_stb_o = mn_cyc_i & mn_stb_i, s_we/sel/adr/dat_o = requester n's inputs, combinationally.
REQ-024 While OWNn: mn_ack_o = s_ack_i & mn_cyc_i, mn_dat_o = s_dat_i, combinationally; other requester sees ack 0, dat 0, err 0.
REQ-025 Owner dropping cyc before ack SHALL abandon the transfer: s_cyc_o/s_stb_o low that same cycle; no state retained.
REQ-026 With both requesters asserting continuously, grants SHALL alternate 0,1,0,1 (round-robin).
REQ-027 A requester raising cyc during the other's ownership SHALL be granted at most one IDLE cycle after that ownership ends.

Reset
REQ-028 On wb_rst_i high at a clock edge: state IDLE, last_owner 1 (m0 wins first tie), timeout counter 0; in that cycle grant_o 2'b00, timeout_o 0, all mN_err_o 0, all slave outputs 0.
REQ-029 Reset asserted mid-transfer SHALL drop s_cyc_o/s_stb_o in the following cycle regardless of s_ack_i; no ack forwarded after reset.

Configuration
REQ-030 Macro I2C_ARB_TIMEOUT_EN defined: 16-bit counter, cleared on every ack or state change, increments each OWNn cycle with s_stb_o high and s_ack_i low; on reaching TIMEOUT_CYCLES -> mn_err_o and timeout_o pulse one cycle, FSM -> IDLE, last_owner <= n, s_cyc_o/s_stb_o low next cycle.
REQ-031 After an abort, the aborted requester SHALL NOT be regranted until it has dropped cyc for at least one cycle.
REQ-032 Macro undefined: no counter logic; timeout_o and mN_err_o tied 0; ownership unbounded.

Verification
REQ-033 Reset then m0 single write adr 0x0000_0004 data 0x55, ack after 3 cycles -> grant_o 2'b01 one cycle after cyc, m0_ack_o one pulse, then grant_o 2'b00.
REQ-034 m0 and m1 raise cyc same cycle, each 4 back-to-back reads -> grant order 01,10,01,10 with one IDLE cycle between owners.
REQ-035 m1 owns, 3-beat locked cycle; m0 requests at beat 1 -> m0 not granted until m1_cyc_i drops, then granted after exactly one IDLE cycle.
REQ-036 TIMEOUT_CYCLES=8, macro defined, slave never acks -> after 8 stall cycles m0_err_o and timeout_o pulse once, grant_o 2'b00; m0 held high not regranted until it drops cyc.
REQ-037 Same stimulus, macro undefined -> no err/timeout pulse, grant_o stays 2'b01 for 100 cycles.
REQ-038 wb_rst_i pulsed during m1 read awaiting ack -> next cycle s_cyc_o 0, grant_o 2'b00; late s_ack_i not forwarded to m1_ack_o.
